// File: rtl/afifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter.
package afifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width for a vector of n entries; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/afifo_rr_picker.sv
// Combinational round-robin search: first set request strictly after i_ptr, wrapping.
module afifo_rr_picker
  import afifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic          w_found;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_pos    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_pos = IW'((32'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_pos]) begin
        w_found         = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin sharing of an async FIFO write port with wfull gating and write/stall statistics.
// Define AFIFO_ARB_BURST_LOCK_EN to keep a grant for up to MAX_BURST consecutive words.
module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_vld,
  output logic [CNT_WIDTH-1:0]          wr_count,
  output logic [CNT_WIDTH-1:0]          stall_count
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  if ((NUM_REQ < 2) || (MAX_BURST < 1)) begin : g_bad_cfg
    $error("afifo_wr_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
  end

  logic [IW-1:0]        r_ptr;
  logic [CNT_WIDTH-1:0] r_wr_count;
  logic [CNT_WIDTH-1:0] r_stall_count;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;

  logic               w_gnt_raw;
  logic [IW-1:0]      w_gnt_id;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_stall;

  afifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

`ifdef AFIFO_ARB_BURST_LOCK_EN
  localparam int unsigned BW = idx_w(MAX_BURST + 1);

  arb_state_e    r_state;
  logic [IW-1:0] r_owner;
  logic [BW-1:0] r_cnt;

  // While locked only the owner competes; a dropped owner valid yields a bubble.
  always_comb begin
    w_gnt_raw = w_pick_any;
    w_gnt_id  = w_pick_idx;
    w_gnt_oh  = w_pick_oh;
    if (r_state == LOCK) begin
      w_gnt_raw = req_valid[r_owner];
      w_gnt_id  = r_owner;
      w_gnt_oh  = NUM_REQ'(1) << r_owner;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (winc && (MAX_BURST > 1)) begin
            r_state <= LOCK;
            r_owner <= w_gnt_id;
            r_cnt   <= BW'(1);
          end
        end
        LOCK: begin
          if (!req_valid[r_owner]) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (winc) begin
            if (r_cnt == BW'(MAX_BURST - 1)) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + BW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign w_gnt_raw = w_pick_any;
  assign w_gnt_id  = w_pick_idx;
  assign w_gnt_oh  = w_pick_oh;
`endif

  // Full gating is combinational so a word is never pushed into a full FIFO.
  assign grant_vld = w_gnt_raw & ~wrst;
  assign winc      = grant_vld & ~wfull;
  assign req_ready = w_gnt_oh & {NUM_REQ{winc}};
  assign grant_id  = w_gnt_id;
  assign wdata     = req_data[32'(w_gnt_id) * DATA_WIDTH +: DATA_WIDTH];
  assign w_stall   = (|req_valid) & wfull;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_ptr         <= IW'(NUM_REQ - 1);
      r_wr_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (winc) begin
        r_ptr      <= w_gnt_id;
        r_wr_count <= r_wr_count + CNT_WIDTH'(1);
      end
      if (w_stall && (r_stall_count != {CNT_WIDTH{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
    end
  end

  assign wr_count    = r_wr_count;
  assign stall_count = r_stall_count;

endmodule
